// File: rtl/regfile_sb_if.sv
// Purpose: decode/writeback-side bundle of the scoreboarded register file.
// Latency: carries combinational reads; writes, reservations and clear act at the clock edge.
// Backpressure: none; clr_busy is the only stall indication (writes/reserves dropped while high).
// Ports: master = decode/writeback (drives regw/regaddrW/wdata, regaddrR, rsv/rsvaddr, clr_req),
//        slave  = register file (drives regdataR, busyR, clr_busy).
interface regfile_sb_if #(
  parameter int N     = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2
);
  localparam int AW = $clog2(NREGS);

  logic              regw;
  logic [AW-1:0]     regaddrW;
  logic [N-1:0]      wdata;
  logic [NRP*AW-1:0] regaddrR;
  logic [NRP*N-1:0]  regdataR;
  logic [NRP-1:0]    busyR;
  logic              rsv;
  logic [AW-1:0]     rsvaddr;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output regw, regaddrW, wdata, regaddrR, rsv, rsvaddr, clr_req,
    input  regdataR, busyR, clr_busy
  );

  modport slave (
    input  regw, regaddrW, wdata, regaddrR, rsv, rsvaddr, clr_req,
    output regdataR, busyR, clr_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// Purpose: NREGS x N integer register file, x0 = 0, write-to-read bypass, busy scoreboard, bulk clear.
// Latency: reads and busy flags are combinational (0 cycles); writes/reserves land on the next edge.
// Backpressure: none; during the NREGS-1 cycle clear (clr_busy=1) writes and reserves are dropped.
// Ports: clock, nreset (async active-low); bus = regfile_sb_if.slave
//        (write port, NRP read ports with busy flags, reserve port, clear request/busy).
module regfile_sb #(
  parameter int N     = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2
) (
  input  logic         clock,
  input  logic         nreset,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t         r_state;
  logic [AW-1:0]  r_cnt;
  logic           r_clr_busy;
  logic [N-1:0]   r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic           w_idle;
  logic           w_wr;
  logic           w_rs;
  logic [AW-1:0]  w_ra [NRP];
  logic [NRP*N-1:0] w_rdata;
  logic [NRP-1:0] w_rbusy;

  // nreset in the qualifiers keeps the outputs at zero while reset is held,
  // even if upstream is already presenting a write.
  assign w_idle = (r_state == S_IDLE);
  assign w_wr   = nreset & bus.regw & w_idle & (bus.regaddrW != '0);
  assign w_rs   = nreset & bus.rsv  & w_idle & (bus.rsvaddr  != '0);

  // Clear sequencer. r_cnt walks 1..NREGS-1 (x0 never needs clearing).
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state    <= S_IDLE;
      r_cnt      <= FIRST_IDX;
      r_clr_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.clr_req) begin
            r_state    <= S_CLEAR;
            r_cnt      <= FIRST_IDX;
            r_clr_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_cnt == LAST_IDX) begin
            r_state    <= S_IDLE;
            r_cnt      <= FIRST_IDX;
            r_clr_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + FIRST_IDX;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= FIRST_IDX;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage and scoreboard.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else if (r_state == S_CLEAR) begin
      r_regs[r_cnt] <= '0;
      r_busy[r_cnt] <= 1'b0;
    end else begin
      if (w_wr) begin
        r_regs[bus.regaddrW] <= bus.wdata;
        r_busy[bus.regaddrW] <= 1'b0;
      end
      // Placed after the write so a same-cycle reserve of the same register
      // wins: the new producer's pending result is what matters.
      if (w_rs) begin
        r_busy[bus.rsvaddr] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NRP; g++) begin : g_ra
    assign w_ra[g] = bus.regaddrR[g*AW +: AW];
  end

  // Read ports. Address 0 falls through to the zero defaults.
  always_comb begin
    w_rdata = '0;
    w_rbusy = '0;
    for (int k = 0; k < NRP; k++) begin
      if (w_ra[k] != '0) begin
        if (w_wr && (bus.regaddrW == w_ra[k])) begin
          w_rdata[k*N +: N] = bus.wdata;
        end else begin
          w_rdata[k*N +: N] = r_regs[w_ra[k]];
        end
        // The write being bypassed retires the pending result, unless a new
        // reservation of the same register arrives in the same cycle.
        if (w_wr && (bus.regaddrW == w_ra[k]) && !(w_rs && (bus.rsvaddr == w_ra[k]))) begin
          w_rbusy[k] = 1'b0;
        end else begin
          w_rbusy[k] = r_busy[w_ra[k]];
        end
      end
    end
  end

  assign bus.regdataR = w_rdata;
  assign bus.busyR    = w_rbusy;
  assign bus.clr_busy = r_clr_busy;
endmodule
